// File: rtl/ask_pkg.sv
// Shared constants, slicer state encoding and symbol-length helpers for the ASK receiver.
package ask_pkg;

    localparam int CARRIER_PERIOD = 50;
    localparam int BIT_PERIOD     = 5001;
    localparam int FULL_SCALE     = 102;
    localparam int AVG_WINDOWS    = 64;
    localparam int AVG_SHIFT      = $clog2(AVG_WINDOWS);

    localparam int SC_W  = 14;
    localparam int WIN_W = 9;
    localparam int WC_W  = $clog2(CARRIER_PERIOD);
    localparam int ACC_W = 14;

    localparam logic [1:0] MIX_OFF  = 2'b00;
    localparam logic [1:0] MIX_2ASK = 2'b01;
    localparam logic [1:0] MIX_4ASK = 2'b10;
    localparam logic [1:0] MIX_8ASK = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SLICE,
        ST_EMIT,
        ST_SHIFT
    } slice_state_t;

    function automatic logic [SC_W-1:0] sym_len(input logic [1:0] k);
        return SC_W'(k) * SC_W'(BIT_PERIOD);
    endfunction

    // Complete carrier windows per symbol; the short tail window is never counted.
    function automatic logic [WIN_W-1:0] win_total(input logic [1:0] k);
        return WIN_W'(sym_len(k) / SC_W'(CARRIER_PERIOD));
    endfunction

endpackage

// File: rtl/ask_peak_detector.sv
// Per-carrier-window running maximum of the ADC samples, with window-complete pulse and index.
module ask_peak_detector
    import ask_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [7:0]       adc_data,
    output logic             window_done,
    output logic [7:0]       window_peak,
    output logic [WIN_W-1:0] window_idx
);

    logic [WC_W-1:0] wc;
    logic [7:0]      peak_q;

    // The peak includes the current sample, so the last sample of a window is never lost.
    assign window_peak = (adc_data > peak_q) ? adc_data : peak_q;
    assign window_done = (wc == WC_W'(CARRIER_PERIOD - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            wc         <= '0;
            peak_q     <= '0;
            window_idx <= '0;
        end else if (window_done) begin
            wc         <= '0;
            peak_q     <= '0;
            window_idx <= window_idx + WIN_W'(1);
        end else begin
            wc         <= wc + WC_W'(1);
            peak_q     <= window_peak;
        end
    end

endmodule

// File: rtl/ask_demodulator.sv
// ASK receiver: symbol timer, trailing-window envelope average, threshold slicer and bit serializer.
module ask_demodulator
    import ask_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] adc_data,
    input  logic [1:0] mix_mode,
    input  logic       sync_start,
    output logic       sym_valid,
    output logic [2:0] sym_data,
    output logic       bit_valid,
    output logic       bit_data,
    output logic [7:0] env_mean
);

    logic [1:0]       mix_q;
    logic [SC_W-1:0]  sc;
    logic [ACC_W-1:0] acc;
    logic             mode_on, mix_changed, restart_req, sym_end, win_restart, acc_en;
    logic             window_done;
    logic [7:0]       window_peak;
    logic [WIN_W-1:0] window_idx;

    slice_state_t state, state_n;
    logic [2:0]   step, step_n;
    logic [1:0]   sym_k, sym_k_n;
    logic [2:0]   sym_reg, sym_reg_n;
    logic         sym_valid_n, bit_valid_n, bit_data_n;
    logic [2:0]   sym_data_n;

    logic [2:0]   lvl_max;
    logic [12:0]  slice_lhs, slice_rhs;
    logic         slice_pass;
    logic [1:0]   bit_idx;

    assign mode_on     = (mix_mode != MIX_OFF);
    assign mix_changed = (mix_mode != mix_q);
    assign restart_req = sync_start || mix_changed;
    // A mode change opens a fresh symbol, so that cycle can never close one.
    assign sym_end     = mode_on && !mix_changed && (sc == sym_len(mix_mode) - SC_W'(1));
    assign win_restart = !mode_on || restart_req || sym_end;
    assign acc_en      = window_done && (window_idx >= win_total(mix_mode) - WIN_W'(AVG_WINDOWS));

    ask_peak_detector u_peak (
        .clk        (clk),
        .rst        (rst),
        .restart    (win_restart),
        .adc_data   (adc_data),
        .window_done(window_done),
        .window_peak(window_peak),
        .window_idx (window_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mix_q    <= MIX_OFF;
            sc       <= '0;
            acc      <= '0;
            env_mean <= '0;
        end else begin
            mix_q <= mix_mode;
            sc    <= win_restart ? '0 : sc + SC_W'(1);
            if (sym_end)
                env_mean <= acc[ACC_W-1:AVG_SHIFT];
            if (win_restart)
                acc <= '0;
            else if (acc_en)
                acc <= acc + ACC_W'(window_peak);
        end
    end

    // Threshold test: mean*2*(L-1) >= (2j-1)*FULL_SCALE, evaluated for j = step.
    assign lvl_max    = 3'((4'd1 << sym_k) - 4'd1);
    assign slice_lhs  = 13'(env_mean) * {9'd0, lvl_max, 1'b0};
    assign slice_rhs  = ({9'd0, step, 1'b0} - 13'd1) * 13'(FULL_SCALE);
    assign slice_pass = (slice_lhs >= slice_rhs) && (step <= lvl_max);
    assign bit_idx    = sym_k - 2'd1 - step[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            step      <= '0;
            sym_k     <= '0;
            sym_reg   <= '0;
            sym_valid <= 1'b0;
            sym_data  <= '0;
            bit_valid <= 1'b0;
            bit_data  <= 1'b0;
        end else begin
            state     <= state_n;
            step      <= step_n;
            sym_k     <= sym_k_n;
            sym_reg   <= sym_reg_n;
            sym_valid <= sym_valid_n;
            sym_data  <= sym_data_n;
            bit_valid <= bit_valid_n;
            bit_data  <= bit_data_n;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_n     = state;
        step_n      = step;
        sym_k_n     = sym_k;
        sym_reg_n   = sym_reg;
        sym_valid_n = 1'b0;
        sym_data_n  = sym_data;
        bit_valid_n = 1'b0;
        bit_data_n  = bit_data;

        case (state)
            ST_IDLE: begin
                if (sym_end) begin
                    state_n   = ST_SLICE;
                    step_n    = 3'd1;
                    sym_k_n   = mix_mode;
                    sym_reg_n = '0;
                end
            end
            ST_SLICE: begin
                if (slice_pass)
                    sym_reg_n = step;
                if (step == 3'd7)
                    state_n = ST_EMIT;
                else
                    step_n = step + 3'd1;
            end
            ST_EMIT: begin
                sym_valid_n = 1'b1;
                sym_data_n  = sym_reg;
                state_n     = ST_SHIFT;
                step_n      = '0;
            end
            ST_SHIFT: begin
                bit_valid_n = 1'b1;
                bit_data_n  = sym_reg[bit_idx];
                if (step == 3'(sym_k) - 3'd1)
                    state_n = ST_IDLE;
                else
                    step_n = step + 3'd1;
            end
            default: state_n = ST_IDLE;
        endcase

        // Switching the receiver off drops any symbol still being sliced or shifted out.
        if (!mode_on) begin
            state_n     = ST_IDLE;
            sym_valid_n = 1'b0;
            bit_valid_n = 1'b0;
        end
    end

endmodule
